// File: rtl/crg_pkg.sv
// Shared types and default timing for the clock-switch sequencer and the CRG top.
package crg_pkg;

  typedef enum logic [2:0] {
    IDLE, GATE, LOCK, SWITCH, UNGATE, RST, ABORT, ACK
  } sw_state_e;

  localparam int DEF_NUM_SRC    = 4;
  localparam int DEF_RESET_SEL  = 0;
  localparam int DEF_GATE_CYC   = 4;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_RST_CYC    = 8;
  localparam int DEF_LOCK_TMO   = 256;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/crg_sync2.sv
// Two-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module crg_sync2 (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/clk_switch_ctrl.sv
// Clock-source switch sequencer: gate, wait for target lock, switch, settle, ungate, optional reset pulse.
// Runs on the reference clock so it keeps sequencing while the generated clock is gated.
module clk_switch_ctrl
  import crg_pkg::*;
#(
  parameter  int NUM_SRC    = DEF_NUM_SRC,
  parameter  int RESET_SEL  = DEF_RESET_SEL,
  parameter  int GATE_CYC   = DEF_GATE_CYC,
  parameter  int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter  int RST_CYC    = DEF_RST_CYC,
  parameter  int LOCK_TMO   = DEF_LOCK_TMO,
  localparam int SEL_W      = $clog2(NUM_SRC)
) (
  input  logic               ref_clk_i,
  input  logic               arst_n_i,
  input  logic               sw_req_i,
  input  logic [SEL_W-1:0]   sw_sel_i,
  input  logic               sw_rst_i,
  input  logic [NUM_SRC-1:0] pll_lock_i,
  output logic               sw_ack_o,
  output logic               sw_err_o,
  output logic               busy_o,
  output logic [SEL_W-1:0]   sel_o,
  output logic               en_o,
  output logic               arst_req_o
);

  localparam int CNT_MAX = max_int(max_int(GATE_CYC, SETTLE_CYC), max_int(RST_CYC, LOCK_TMO));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(LOCK_TMO - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYC - 1);

  sw_state_e          r_state;
  sw_state_e          w_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SEL_W-1:0]   r_tgt;
  logic               r_rst;
  logic [SEL_W-1:0]   r_sel;
  logic               r_en;
  logic               r_arst;
  logic               r_ack;
  logic               r_err;
  logic               r_busy;
  logic [NUM_SRC-1:0] w_lock_s;
  logic               w_capture;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lock_sync
    crg_sync2 u_sync (
      .clk_i    (ref_clk_i),
      .arst_n_i (arst_n_i),
      .d_i      (pll_lock_i[g]),
      .q_o      (w_lock_s[g])
    );
  end

  assign w_capture = (r_state == IDLE) && sw_req_i;

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      IDLE: begin
        if (sw_req_i) begin
          if ((sw_sel_i == r_sel) && !sw_rst_i) begin
            w_nxt = ACK;
          end else begin
            w_nxt     = GATE;
            w_cnt_nxt = GATE_LD;
          end
        end
      end
      GATE: begin
        if (r_cnt == '0) begin
          w_nxt     = LOCK;
          w_cnt_nxt = TMO_LD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      LOCK: begin
        if (w_lock_s[r_tgt]) begin
          w_nxt     = SWITCH;
          w_cnt_nxt = SETTLE_LD;
        end else if (r_cnt == '0) begin
          w_nxt = ABORT;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      SWITCH: begin
        if (r_cnt == '0) w_nxt = UNGATE;
        else             w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      UNGATE: begin
        if (r_rst) begin
          w_nxt     = RST;
          w_cnt_nxt = RST_LD;
        end else begin
          w_nxt = ACK;
        end
      end
      RST: begin
        if (r_cnt == '0) w_nxt = ACK;
        else             w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      ABORT:   w_nxt = ACK;
      ACK:     if (!sw_req_i) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every output is a flop aligned with r_state.
  always_ff @(posedge ref_clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tgt   <= '0;
      r_rst   <= 1'b0;
      r_sel   <= SEL_W'(RESET_SEL);
      r_en    <= 1'b1;
      r_arst  <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_tgt <= sw_sel_i;
        r_rst <= sw_rst_i;
      end
      if (w_nxt == SWITCH) r_sel <= r_tgt;
      r_en   <= !((w_nxt == GATE) || (w_nxt == LOCK) || (w_nxt == SWITCH));
      r_arst <= (w_nxt == RST);
      r_ack  <= (w_nxt == ACK);
      r_err  <= (w_nxt == ACK) && ((r_state == ABORT) || r_err);
      r_busy <= (w_nxt != IDLE);
    end
  end

  assign sw_ack_o   = r_ack;
  assign sw_err_o   = r_err;
  assign busy_o     = r_busy;
  assign sel_o      = r_sel;
  assign en_o       = r_en;
  assign arst_req_o = r_arst;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl with default parameters and hand-computed cycle counts.
module tb_clk_switch_ctrl;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       sw_req;
  logic [1:0] sw_sel;
  logic       sw_rst;
  logic [3:0] pll_lock;
  logic       sw_ack;
  logic       sw_err;
  logic       busy;
  logic [1:0] sel;
  logic       en;
  logic       arst_req;

  int n_total = 0;
  int n_bad   = 0;
  int en_low, sel_first, en_rise, arst_cnt, arst_first, ack_first, viol;

  always #5 clk = ~clk;

  clk_switch_ctrl dut (
    .ref_clk_i  (clk),
    .arst_n_i   (arst_n),
    .sw_req_i   (sw_req),
    .sw_sel_i   (sw_sel),
    .sw_rst_i   (sw_rst),
    .pll_lock_i (pll_lock),
    .sw_ack_o   (sw_ack),
    .sw_err_o   (sw_err),
    .busy_o     (busy),
    .sel_o      (sel),
    .en_o       (en),
    .arst_req_o (arst_req)
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one request until ack (bounded) and records when each output event happened.
  task automatic run_seq(input logic [1:0] tgt, input int chg_at, input int drop_at);
    logic [1:0] prev_sel;
    logic       prev_en;
    bit         done;
    en_low = 0; sel_first = -1; en_rise = -1;
    arst_cnt = 0; arst_first = -1; ack_first = -1; viol = 0;
    prev_sel = sel;
    prev_en  = en;
    done     = 1'b0;
    for (int i = 1; i <= 400 && !done; i++) begin
      step();
      if (!en) en_low++;
      if (en && !prev_en && en_rise < 0) en_rise = i;
      if (sel != prev_sel && sel_first < 0) sel_first = i;
      if (sel != prev_sel && en) viol++;
      if (arst_req && !en) viol++;
      if (arst_req) begin
        arst_cnt++;
        if (arst_first < 0) arst_first = i;
      end
      prev_sel = sel;
      prev_en  = en;
      if (i == chg_at) sw_sel = tgt + 2'd1;
      if (i == drop_at) sw_req = 1'b0;
      if (sw_ack) begin
        ack_first = i;
        done = 1'b1;
      end
    end
  endtask

  task automatic request(input logic [1:0] s, input logic r);
    sw_sel = s;
    sw_rst = r;
    sw_req = 1'b1;
  endtask

  initial begin
    int hold_ok;
    arst_n = 1'b0; sw_req = 1'b0; sw_sel = 2'd0; sw_rst = 1'b0; pll_lock = 4'b0111;
    #12;
    chk("rst_sel", sel, 0);
    chk("rst_en", en, 1);
    chk("rst_arst", arst_req, 0);
    chk("rst_ack", sw_ack, 0);
    chk("rst_err", sw_err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) arst_n = 1'b1;
    repeat (5) step();

    // Switch to 2 without reset; target select changed mid-sequence must be ignored.
    request(2'd2, 1'b0);
    run_seq(2'd2, 3, 0);
    chk("s2_en_low", en_low, 9);
    chk("s2_sel_first", sel_first, 6);
    chk("s2_en_rise", en_rise, 10);
    chk("s2_ack", ack_first, 11);
    chk("s2_arst", arst_cnt, 0);
    chk("s2_err", sw_err, 0);
    chk("s2_sel", sel, 2);
    chk("s2_viol", viol, 0);
    hold_ok = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sw_ack && busy && en && sel == 2'd2) hold_ok++;
    end
    chk("hold_ack", hold_ok, 10);
    sw_req = 1'b0;
    step();
    chk("s2_clr_ack", sw_ack, 0);
    chk("s2_clr_busy", busy, 0);

    // Switch to 1 with reset pulse.
    step();
    request(2'd1, 1'b1);
    run_seq(2'd1, 0, 0);
    chk("s1_en_low", en_low, 9);
    chk("s1_sel_first", sel_first, 6);
    chk("s1_en_rise", en_rise, 10);
    chk("s1_arst_first", arst_first, 11);
    chk("s1_arst_cnt", arst_cnt, 8);
    chk("s1_ack", ack_first, 19);
    chk("s1_arst_at_ack", arst_req, 0);
    chk("s1_err", sw_err, 0);
    chk("s1_viol", viol, 0);
    sw_req = 1'b0;
    step();

    // Target 3 never locks: abort after the full timeout.
    step();
    request(2'd3, 1'b0);
    run_seq(2'd3, 0, 0);
    chk("ab_en_low", en_low, 260);
    chk("ab_sel_first", sel_first, -1);
    chk("ab_en_rise", en_rise, 261);
    chk("ab_ack", ack_first, 262);
    chk("ab_err", sw_err, 1);
    chk("ab_sel", sel, 1);
    sw_req = 1'b0;
    step();
    chk("ab_clr_err", sw_err, 0);
    chk("ab_clr_ack", sw_ack, 0);

    // Fast path: already on the requested source.
    step();
    request(2'd1, 1'b0);
    run_seq(2'd1, 0, 0);
    chk("fp_ack", ack_first, 1);
    chk("fp_en_low", en_low, 0);
    chk("fp_busy", busy, 1);
    chk("fp_err", sw_err, 0);
    sw_req = 1'b0;
    step();
    chk("fp_busy_clr", busy, 0);
    chk("fp_ack_clr", sw_ack, 0);

    // Asynchronous reset in the middle of SWITCH.
    step();
    request(2'd2, 1'b0);
    repeat (7) step();
    chk("mid_sel", sel, 2);
    chk("mid_en", en, 0);
    #3 arst_n = 1'b0;
    #1;
    chk("ar_sel", sel, 0);
    chk("ar_en", en, 1);
    chk("ar_arst", arst_req, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ack", sw_ack, 0);
    sw_req = 1'b0;
    @(negedge clk) arst_n = 1'b1;
    step();
    step();
    chk("ar_idle_busy", busy, 0);
    chk("ar_idle_sel", sel, 0);

    // Request dropped early: sequence still completes and ack clears next cycle.
    request(2'd2, 1'b0);
    run_seq(2'd2, 0, 2);
    chk("dr_ack", ack_first, 11);
    chk("dr_sel", sel, 2);
    step();
    chk("dr_ack_clr", sw_ack, 0);
    chk("dr_busy_clr", busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
